// File: rtl/nts_rx_buffer_core_if.sv
// Access port between the parser controller and the NTS receive buffer.
// Read request with wait back-pressure and a one-cycle data-valid pulse.
interface nts_rx_buffer_core_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  access_port_wait;
  logic [ADDR_WIDTH+2:0] access_port_addr;
  logic [2:0]            access_port_wordsize;
  logic                  access_port_rd_en;
  logic                  access_port_rd_dv;
  logic [63:0]           access_port_rd_data;

  modport master (
    input  access_port_wait,
    input  access_port_rd_dv,
    input  access_port_rd_data,
    output access_port_addr,
    output access_port_wordsize,
    output access_port_rd_en
  );

  modport slave (
    output access_port_wait,
    output access_port_rd_dv,
    output access_port_rd_data,
    input  access_port_addr,
    input  access_port_wordsize,
    input  access_port_rd_en
  );
endinterface

// File: rtl/nts_rx_buffer_core.sv
// NTS receive buffer: copies a dispatched packet into a 64-bit RAM and
// serves big-endian 1/2/4/8-byte reads to the parser.
module nts_rx_buffer_core #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        i_clk,
  input  logic        i_areset_n,
  input  logic        i_clear,
  input  logic        i_dispatch_packet_available,
  input  logic        i_dispatch_fifo_empty,
  output logic        o_dispatch_fifo_rd_en,
  input  logic [63:0] i_dispatch_fifo_rd_data,
  nts_rx_buffer_core_if.slave ap
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    C_IDLE,
    C_COPY,
    C_DONE
  } cstate_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WORD0,
    R_WORD1,
    R_DV
  } rstate_t;

  cstate_t c_q, c_d;
  rstate_t r_q, r_d;

  logic [ADDR_WIDTH:0]   wptr_q;
  logic [63:0]           mem [DEPTH];
  logic [63:0]           ram_q;
  logic [63:0]           hi_q;
  logic [63:0]           rd_data_q;
  logic [ADDR_WIDTH+2:0] addr_q;
  logic [2:0]            ws_q;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [3:0]            nbytes;
  logic [3:0]            span;
  logic                  accept;
  logic                  straddle;
  logic                  ram_we;
  logic                  ram_rd;
  logic                  out_load;
  logic [127:0]          window;
  logic [127:0]          shifted;
  logic [63:0]           result;

  always_comb begin
    c_d = c_q;
    o_dispatch_fifo_rd_en = 1'b0;
    if (i_clear) begin
      c_d = C_IDLE;
    end else begin
      unique case (c_q)
        C_IDLE: begin
          o_dispatch_fifo_rd_en =
            !i_dispatch_fifo_empty &&
            i_dispatch_packet_available;
          if (o_dispatch_fifo_rd_en) c_d = C_COPY;
        end
        C_COPY: begin
          o_dispatch_fifo_rd_en = !i_dispatch_fifo_empty;
          if (i_dispatch_fifo_empty) c_d = C_DONE;
        end
        default: c_d = C_DONE;
      endcase
    end
  end

  // Past the last word the pointer parks at DEPTH and further pops are dropped.
  assign ram_we = o_dispatch_fifo_rd_en && !wptr_q[ADDR_WIDTH];

  assign ap.access_port_wait = (c_q == C_COPY) || (r_q != R_IDLE);
  assign ap.access_port_rd_dv = (r_q == R_DV);
  assign ap.access_port_rd_data = rd_data_q;

  assign accept = ap.access_port_rd_en &&
                  !ap.access_port_wait && !i_clear;

  assign nbytes = 4'd1 << ws_q[1:0];
  assign span = {1'b0, addr_q[2:0]} + nbytes;
  assign straddle = !ws_q[2] && (span > 4'd8);

  always_comb begin
    r_d = r_q;
    if (i_clear) begin
      r_d = R_IDLE;
    end else begin
      unique case (r_q)
        R_IDLE:  if (accept) r_d = R_WORD0;
        R_WORD0: r_d = straddle ? R_WORD1 : R_DV;
        R_WORD1: r_d = R_DV;
        R_DV:    r_d = R_IDLE;
        default: r_d = R_IDLE;
      endcase
    end
  end

  // The first word is fetched straight off the request so it lands in WORD0.
  assign raddr = (r_q == R_IDLE) ?
    ap.access_port_addr[ADDR_WIDTH+2:3] :
    addr_q[ADDR_WIDTH+2:3] + ADDR_WIDTH'(1);
  assign ram_rd = accept || ((r_q == R_WORD0) && straddle);
  assign out_load = ((r_q == R_WORD0) && !straddle) ||
                    (r_q == R_WORD1);

  assign window = (r_q == R_WORD1) ? {hi_q, ram_q} :
                                     {ram_q, 64'd0};
  assign shifted = window << {addr_q[2:0], 3'b000};

  always_comb begin
    result = 64'd0;
    unique case (ws_q)
      3'd0:    result = {56'd0, shifted[127:120]};
      3'd1:    result = {48'd0, shifted[127:112]};
      3'd2:    result = {32'd0, shifted[127:96]};
      3'd3:    result = shifted[127:64];
      default: result = 64'd0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (ram_we) mem[wptr_q[ADDR_WIDTH-1:0]] <= i_dispatch_fifo_rd_data;
    if (ram_rd) ram_q <= mem[raddr];
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      c_q       <= C_IDLE;
      r_q       <= R_IDLE;
      wptr_q    <= '0;
      addr_q    <= '0;
      ws_q      <= '0;
      hi_q      <= '0;
      rd_data_q <= '0;
    end else if (i_clear) begin
      c_q       <= C_IDLE;
      r_q       <= R_IDLE;
      wptr_q    <= '0;
      rd_data_q <= '0;
    end else begin
      c_q <= c_d;
      r_q <= r_d;
      if (ram_we) wptr_q <= wptr_q + 1'b1;
      if (accept) begin
        addr_q <= ap.access_port_addr;
        ws_q   <= ap.access_port_wordsize;
      end
      if (r_q == R_WORD0) hi_q <= ram_q;
      if (out_load) rd_data_q <= result;
    end
  end

endmodule

// File: tb/tb_nts_rx_buffer_core.sv
// Bench for nts_rx_buffer_core: copy, read table, handshake,
// clear/reset and overflow, checked through a read scoreboard.
module tb_nts_rx_buffer_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  nts_rx_buffer_core_if #(.ADDR_WIDTH(10)) ap0 ();
  nts_rx_buffer_core_if #(.ADDR_WIDTH(2))  ap1 ();

  logic        avail0 = 1'b0;
  logic        avail1 = 1'b0;
  logic        ren0, ren1;
  logic        empty0, empty1;
  logic [63:0] fdata0, fdata1;
  logic [63:0] fmem0 [16];
  logic [63:0] fmem1 [16];
  int head0 = 0;
  int cnt0 = 0;
  int head1 = 0;
  int cnt1 = 0;

  assign empty0 = (head0 == cnt0);
  assign empty1 = (head1 == cnt1);
  assign fdata0 = fmem0[head0[3:0]];
  assign fdata1 = fmem1[head1[3:0]];
  always @(posedge clk) if (ren0) head0 <= head0 + 1;
  always @(posedge clk) if (ren1) head1 <= head1 + 1;

  nts_rx_buffer_core #(.ADDR_WIDTH(10)) dut0 (
    .i_clk                       (clk),
    .i_areset_n                  (rst_n),
    .i_clear                     (clear),
    .i_dispatch_packet_available (avail0),
    .i_dispatch_fifo_empty       (empty0),
    .o_dispatch_fifo_rd_en       (ren0),
    .i_dispatch_fifo_rd_data     (fdata0),
    .ap                          (ap0.slave)
  );

  nts_rx_buffer_core #(.ADDR_WIDTH(2)) dut1 (
    .i_clk                       (clk),
    .i_areset_n                  (rst_n),
    .i_clear                     (clear),
    .i_dispatch_packet_available (avail1),
    .i_dispatch_fifo_empty       (empty1),
    .o_dispatch_fifo_rd_en       (ren1),
    .i_dispatch_fifo_rd_data     (fdata1),
    .ap                          (ap1.slave)
  );

  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [12:0] addr;
    logic [2:0]  ws;
    logic [63:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // One cycle; any rd_dv seen is matched against the scoreboard.
  task automatic tick();
    exp_t e;
    logic [63:0] d;
    @(negedge clk);
    #1;
    if (ap0.access_port_rd_dv || ap1.access_port_rd_dv) begin
      d = ap0.access_port_rd_dv ? ap0.access_port_rd_data :
                                  ap1.access_port_rd_data;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_dv: got rd_dv=1 required 0 (cycle %0d)",
                 cyc);
      end else begin
        e = sb.pop_front();
        chk("rd_data", d, e.data);
        chk("rd_latency", 64'(cyc), 64'(e.due));
      end
    end
  endtask

  task automatic set_req(input bit sel, input logic [12:0] a,
                         input logic [2:0] ws, input logic en);
    if (!sel) begin
      ap0.access_port_addr = a;
      ap0.access_port_wordsize = ws;
      ap0.access_port_rd_en = en;
    end else begin
      ap1.access_port_addr = a[4:0];
      ap1.access_port_wordsize = ws;
      ap1.access_port_rd_en = en;
    end
  endtask

  function automatic logic wait_of(input bit sel);
    return sel ? ap1.access_port_wait : ap0.access_port_wait;
  endfunction

  task automatic drain(input bit sel);
    for (int i = 0; i < 8 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL dv_timeout: got no rd_dv required %0d pending",
               sb.size());
      sb.delete();
    end
    tick();
    chk("wait_after_dv", 64'(wait_of(sel)), 64'd0);
  endtask

  task automatic rd(input bit sel, input logic [12:0] a,
                    input logic [2:0] ws, input logic [63:0] exp,
                    input int lat);
    set_req(sel, a, ws, 1'b1);
    sb.push_back('{exp, cyc + lat});
    tick();
    set_req(sel, a, ws, 1'b0);
    chk("wait_pending", 64'(wait_of(sel)), 64'd1);
    drain(sel);
  endtask

  task automatic wait_copy(input bit sel);
    int n;
    n = 0;
    while (n < 20 && !(sel ? (empty1 && !ap1.access_port_wait) :
                             (empty0 && !ap0.access_port_wait))) begin
      tick();
      n++;
    end
    chk("copy_done", 64'(n < 20), 64'd1);
  endtask

  initial begin
    vecs[0]  = '{13'd0,  3'd3, 64'h0011223344556677, 2};
    vecs[1]  = '{13'd9,  3'd0, 64'h99, 2};
    vecs[2]  = '{13'd10, 3'd1, 64'hAABB, 2};
    vecs[3]  = '{13'd20, 3'd2, 64'h05060708, 2};
    vecs[4]  = '{13'd6,  3'd2, 64'h66778899, 3};
    vecs[5]  = '{13'd15, 3'd1, 64'hFF01, 3};
    vecs[6]  = '{13'd7,  3'd3, 64'h778899AABBCCDDEE, 3};
    vecs[7]  = '{13'd5,  3'd5, 64'h0, 2};
    vecs[8]  = '{13'd16, 3'd0, 64'h01, 2};
    vecs[9]  = '{13'd12, 3'd2, 64'hCCDDEEFF, 2};
    vecs[10] = '{13'd14, 3'd2, 64'hEEFF0102, 3};
    vecs[11] = '{13'd8,  3'd7, 64'h0, 2};

    set_req(1'b0, 13'd0, 3'd0, 1'b0);
    set_req(1'b1, 13'd0, 3'd0, 1'b0);
    repeat (2) tick();
    chk("reset_wait", 64'(ap0.access_port_wait), 64'd0);
    chk("reset_dv", 64'(ap0.access_port_rd_dv), 64'd0);
    chk("reset_data", ap0.access_port_rd_data, 64'd0);
    chk("reset_fifo_rd_en", 64'(ren0), 64'd0);
    rst_n = 1'b1;
    tick();

    fmem0[0] = 64'h0011223344556677;
    fmem0[1] = 64'h8899AABBCCDDEEFF;
    fmem0[2] = 64'h0102030405060708;
    cnt0 = 3;
    avail0 = 1'b1;
    tick();
    chk("wait_in_copy", 64'(ap0.access_port_wait), 64'd1);
    set_req(1'b0, 13'd0, 3'd3, 1'b1);
    tick();
    set_req(1'b0, 13'd0, 3'd3, 1'b0);
    wait_copy(1'b0);
    chk("copy_pops", 64'(head0), 64'd3);
    chk("done_wait", 64'(ap0.access_port_wait), 64'd0);
    avail0 = 1'b0;
    repeat (4) tick();

    for (int i = 0; i < 12; i++)
      rd(1'b0, vecs[i].addr, vecs[i].ws, vecs[i].exp, vecs[i].lat);

    // A second strobe while the first read is pending must be ignored.
    set_req(1'b0, 13'd9, 3'd0, 1'b1);
    sb.push_back('{64'h99, cyc + 2});
    tick();
    set_req(1'b0, 13'd0, 3'd3, 1'b1);
    tick();
    set_req(1'b0, 13'd0, 3'd3, 1'b0);
    repeat (5) tick();
    chk("second_req_dropped", 64'(sb.size()), 64'd0);
    sb.delete();
    chk("idle_wait", 64'(ap0.access_port_wait), 64'd0);

    // Clear in the middle of a read: no pulse, data cleared.
    set_req(1'b0, 13'd0, 3'd3, 1'b1);
    tick();
    set_req(1'b0, 13'd0, 3'd3, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (4) tick();
    chk("clear_read_wait", 64'(ap0.access_port_wait), 64'd0);
    chk("clear_data", ap0.access_port_rd_data, 64'd0);

    // Clear in the middle of a copy: pointer back to word 0.
    fmem0[3] = 64'hA0A0A0A0A0A0A0A0;
    fmem0[4] = 64'hA1A1A1A1A1A1A1A1;
    fmem0[5] = 64'hA2A2A2A2A2A2A2A2;
    fmem0[6] = 64'hA3A3A3A3A3A3A3A3;
    cnt0 = 7;
    avail0 = 1'b1;
    repeat (2) tick();
    clear = 1'b1;
    avail0 = 1'b0;
    #1;
    chk("clear_fifo_rd_en", 64'(ren0), 64'd0);
    tick();
    clear = 1'b0;
    chk("clear_copy_wait", 64'(ap0.access_port_wait), 64'd0);
    chk("clear_pops", 64'(head0), 64'd5);
    avail0 = 1'b1;
    tick();
    wait_copy(1'b0);
    chk("recopy_pops", 64'(head0), 64'd7);
    avail0 = 1'b0;
    rd(1'b0, 13'd0, 3'd3, 64'hA2A2A2A2A2A2A2A2, 2);
    rd(1'b0, 13'd8, 3'd3, 64'hA3A3A3A3A3A3A3A3, 2);

    // Async reset while rd_dv is high.
    set_req(1'b0, 13'd0, 3'd3, 1'b1);
    sb.push_back('{64'hA2A2A2A2A2A2A2A2, cyc + 2});
    tick();
    set_req(1'b0, 13'd0, 3'd3, 1'b0);
    tick();
    chk("pre_reset_dv", 64'(ap0.access_port_rd_dv), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_dv", 64'(ap0.access_port_rd_dv), 64'd0);
    chk("async_data", ap0.access_port_rd_data, 64'd0);
    chk("async_wait", 64'(ap0.access_port_wait), 64'd0);
    tick();
    rst_n = 1'b1;
    sb.delete();
    tick();

    // Overflow on a 4-word buffer: six words popped, four kept.
    for (int i = 0; i < 6; i++)
      fmem1[i] = 64'h1111111111111111 * 64'(i + 1);
    cnt1 = 6;
    avail1 = 1'b1;
    tick();
    wait_copy(1'b1);
    chk("ovf_pops", 64'(head1), 64'd6);
    avail1 = 1'b0;
    rd(1'b1, 13'd24, 3'd3, 64'h4444444444444444, 2);
    rd(1'b1, 13'd0,  3'd3, 64'h1111111111111111, 2);
    rd(1'b1, 13'd16, 3'd3, 64'h3333333333333333, 2);
    rd(1'b1, 13'd31, 3'd1, 64'h4411, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
